// File: rtl/wb_cmd_initiator_pkg.sv
// Shared types and constants for the Wishbone command initiator.
// Holds the FSM state encoding and the response status codes.
// No logic lives here.
package wb_cmd_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_TIMEOUT = 2'b01;
    localparam logic [1:0] RSP_BUS_ERR = 2'b10;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: counts run cycles, flags the last permitted one.
// Latency: expired_o is combinational from the count register; count updates each edge.
// Backpressure: none; clear_i has priority over run_i, count saturates instead of wrapping.
module wb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise step while running until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i && (cnt_q != SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i && (cnt_q == LAST);

endmodule

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic initiator: one bus cycle per command, result on a response channel.
// Latency: command edge T -> cyc/stb at T+1 -> earliest response visible after edge T+1.
// Backpressure: single outstanding transaction; cmd_ready low from accept until rsp handshake.
// Optional build macro WB_CMD_INITIATOR_ERR_EN adds the wbm_err_i bus-error input.
module wb_cmd_initiator
    import wb_cmd_initiator_pkg::*;
#(
    parameter int ADR_W          = 32,
    parameter int DAT_W          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_we,
    input  logic [ADR_W-1:0]   cmd_adr,
    input  logic [DAT_W-1:0]   cmd_dat,
    input  logic [DAT_W/8-1:0] cmd_sel,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DAT_W-1:0]   rsp_dat,
    output logic [1:0]         rsp_code,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [DAT_W/8-1:0] wbm_sel_o,
    output logic [ADR_W-1:0]   wbm_adr_o,
    output logic [DAT_W-1:0]   wbm_dat_o,
`ifdef WB_CMD_INITIATOR_ERR_EN
    input  logic               wbm_err_i,
`endif
    input  logic               wbm_ack_i,
    input  logic [DAT_W-1:0]   wbm_dat_i
);

    wb_state_e          state_q, state_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               cyc_q, cyc_d;
    logic               we_q, we_d;
    logic [DAT_W/8-1:0] sel_q, sel_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [DAT_W-1:0]   dat_q, dat_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
    logic [1:0]         rsp_code_q, rsp_code_d;
    logic               ctr_clear, ctr_run, ctr_expired;
    logic               err_w;

`ifdef WB_CMD_INITIATOR_ERR_EN
    assign err_w = wbm_err_i;
`else
    assign err_w = 1'b0;
`endif

    wb_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .clear_i  (ctr_clear),
        .run_i    (ctr_run),
        .expired_o(ctr_expired)
    );

    // Next-state and next-output logic; ack beats err beats timeout.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_code_d  = rsp_code_q;
        ctr_clear   = 1'b0;
        ctr_run     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ctr_clear = 1'b1;
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    sel_d   = cmd_sel;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    cyc_d   = 1'b1;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_code_d  = RSP_OK;
                    rsp_dat_d   = we_q ? '0 : wbm_dat_i;
                    state_d     = ST_RESP;
                end else if (err_w) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_code_d  = RSP_BUS_ERR;
                    rsp_dat_d   = '0;
                    state_d     = ST_RESP;
                end else begin
                    ctr_run = 1'b1;
                    if (ctr_expired) begin
                        cyc_d       = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_code_d  = RSP_TIMEOUT;
                        rsp_dat_d   = '0;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        // Registered ready: high exactly while the next state is IDLE.
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset drops cyc/stb and any pending response at once.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_code_q  <= RSP_OK;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_code_q  <= rsp_code_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_code  = rsp_code_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Self-checking bench for wb_cmd_initiator with a response scoreboard.
// Inputs driven and outputs sampled on the falling clock edge.
// Built with or without WB_CMD_INITIATOR_ERR_EN.
module tb_wb_cmd_initiator;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int TO    = 8;
    localparam logic [31:0] IDLE_DAT = 32'hA5A5_A5A5;

    typedef struct packed {
        logic [1:0]       code;
        logic [DAT_W-1:0] dat;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               cmd_valid, cmd_ready, cmd_we;
    logic [ADR_W-1:0]   cmd_adr;
    logic [DAT_W-1:0]   cmd_dat;
    logic [DAT_W/8-1:0] cmd_sel;
    logic               rsp_valid, rsp_ready;
    logic [DAT_W-1:0]   rsp_dat;
    logic [1:0]         rsp_code;
    logic               wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [DAT_W/8-1:0] wbm_sel_o;
    logic [ADR_W-1:0]   wbm_adr_o;
    logic [DAT_W-1:0]   wbm_dat_o;
    logic               wbm_ack_i;
    logic [DAT_W-1:0]   wbm_dat_i;
`ifdef WB_CMD_INITIATOR_ERR_EN
    logic               wbm_err_i;
`endif

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    wb_cmd_initiator #(
        .ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_dat(rsp_dat), .rsp_code(rsp_code),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
`ifdef WB_CMD_INITIATOR_ERR_EN
        .wbm_err_i(wbm_err_i),
`endif
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a command for one accepting edge; returns at the falling edge after it.
    task automatic drive_cmd(input logic we, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Wait for a response, pop the scoreboard, compare, then handshake it away.
    task automatic collect_rsp(input string name);
        exp_t e;
        int   n = 0;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!rsp_valid) begin
            bad++;
            $display("FAIL %s rsp_wait: rsp_valid=%b want 1 within 30 cycles", name, rsp_valid);
        end else if (q.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard: response seen, queue size=%0d want >0", name, q.size());
        end else begin
            e = q.pop_front();
            total++;
            if (rsp_code !== e.code) begin
                bad++;
                $display("FAIL %s rsp_code: got %b want %b", name, rsp_code, e.code);
            end
            total++;
            if (rsp_dat !== e.dat) begin
                bad++;
                $display("FAIL %s rsp_dat: got %h want %h", name, rsp_dat, e.dat);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s post_hs: rsp_valid=%b cmd_ready=%b want 0 1", name, rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({cmd_ready, rsp_valid, rsp_dat, rsp_code, wbm_cyc_o, wbm_stb_o, wbm_we_o,
             wbm_sel_o, wbm_adr_o, wbm_dat_o} !== {1'b1, 1'b0, 32'h0, 2'b00, 3'b000, 4'h0, 32'h0, 32'h0}) begin
            bad++;
            $display("FAIL reset: rdy=%b rv=%b rd=%h rc=%b cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h want 1 0 0 00 0 0 0 0 0 0",
                     cmd_ready, rsp_valid, rsp_dat, rsp_code, wbm_cyc_o, wbm_stb_o, wbm_we_o,
                     wbm_sel_o, wbm_adr_o, wbm_dat_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_write;
        q.push_back('{code: 2'b00, dat: 32'h0});
        drive_cmd(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        total++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, cmd_ready}
            !== {3'b111, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1'b0}) begin
            bad++;
            $display("FAIL write_bus: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h rdy=%b want 111 30000004 deadbeef f 0",
                     wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, cmd_ready);
        end
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        total++;
        if (rsp_valid !== 1'b1 || wbm_cyc_o !== 1'b0) begin
            bad++;
            $display("FAIL write_latency: rsp_valid=%b cyc=%b want 1 0", rsp_valid, wbm_cyc_o);
        end
        collect_rsp("single_write");
    endtask

    task automatic test_read_wait;
        int n = 0;
        q.push_back('{code: 2'b00, dat: 32'h1234_5678});
        drive_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        while (wbm_cyc_o && n < 20) begin
            n++;
            total++;
            if ({wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o} !== {2'b10, 32'h3000_0010, 4'hF}) begin
                bad++;
                $display("FAIL read_stable: stb=%b we=%b adr=%h sel=%h want 1 0 30000010 f",
                         wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o);
            end
            if (n == 4) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = 32'h1234_5678;
            end
            @(negedge clk);
            wbm_ack_i = 1'b0;
            wbm_dat_i = IDLE_DAT;
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL read_stb_cycles: got %0d want 4", n);
        end
        collect_rsp("read_wait");
    endtask

    task automatic test_timeout(input bit late_ack);
        int n = 0;
        q.push_back(late_ack ? '{code: 2'b00, dat: 32'h0BAD_F00D} : '{code: 2'b01, dat: 32'h0});
        drive_cmd(1'b0, 32'h3000_0020, 32'h0, 4'h3);
        while (wbm_cyc_o && n < 20) begin
            n++;
            if (late_ack && n == TO) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = 32'h0BAD_F00D;
            end
            @(negedge clk);
            wbm_ack_i = 1'b0;
            wbm_dat_i = IDLE_DAT;
        end
        total++;
        if (n != TO) begin
            bad++;
            $display("FAIL timeout_stb_cycles(late_ack=%0d): got %0d want %0d", late_ack, n, TO);
        end
        collect_rsp(late_ack ? "timeout_ack_wins" : "timeout");
    endtask

    task automatic test_back_pressure;
        logic [31:0] d0;
        logic [1:0]  c0;
        q.push_back('{code: 2'b00, dat: 32'h0});
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0040;
        cmd_dat = 32'hCAFE_0001; cmd_sel = 4'h1;
        @(negedge clk);
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        d0 = rsp_dat;
        c0 = rsp_code;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rsp_valid !== 1'b1 || rsp_dat !== d0 || rsp_code !== c0 ||
                cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: rv=%b rd=%h rc=%b rdy=%b cyc=%b want 1 %h %b 0 0",
                         i, rsp_valid, rsp_dat, rsp_code, cmd_ready, wbm_cyc_o, d0, c0);
            end
            @(negedge clk);
        end
        // cmd_valid still high: the DUT must wait for the handshake edge plus one.
        collect_rsp("back_pressure");
        total++;
        if (wbm_cyc_o !== 1'b0) begin
            bad++;
            $display("FAIL bp_no_overlap: cyc=%b want 0 at handshake+0", wbm_cyc_o);
        end
        q.push_back('{code: 2'b00, dat: 32'h0});
        @(negedge clk);
        cmd_valid = 1'b0;
        total++;
        if (wbm_cyc_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_next_cycle: cyc=%b want 1 one edge after handshake", wbm_cyc_o);
        end
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        collect_rsp("back_pressure_2nd");
    endtask

    task automatic test_back_to_back;
        logic        we;
        logic [31:0] adr, rd;
        int          ws;
        for (int i = 0; i < 6; i++) begin
            we  = 1'($urandom_range(0, 1));
            adr = $urandom & 32'hFFFF_FFFC;
            rd  = $urandom;
            ws  = $urandom_range(0, 3);
            q.push_back('{code: 2'b00, dat: we ? 32'h0 : rd});
            drive_cmd(we, adr, ~rd, 4'(i));
            total++;
            if (wbm_cyc_o !== 1'b1 || wbm_we_o !== we || wbm_adr_o !== adr) begin
                bad++;
                $display("FAIL b2b_bus[%0d]: cyc=%b we=%b adr=%h want 1 %b %h", i, wbm_cyc_o, wbm_we_o, wbm_adr_o, we, adr);
            end
            repeat (ws) @(negedge clk);
            wbm_ack_i = 1'b1;
            wbm_dat_i = rd;
            @(negedge clk);
            wbm_ack_i = 1'b0;
            wbm_dat_i = IDLE_DAT;
            collect_rsp("back_to_back");
        end
    endtask

    task automatic test_reset_mid;
        drive_cmd(1'b0, 32'h3000_0080, 32'h0, 4'hF);
        #2 rst = 1'b1;
        #1;
        total++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_async: cyc=%b stb=%b want 0 0 before next edge", wbm_cyc_o, wbm_stb_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_release: rdy=%b rv=%b want 1 0", cmd_ready, rsp_valid);
        end
        wbm_ack_i = 1'b1;
        repeat (2) @(negedge clk);
        wbm_ack_i = 1'b0;
        total++;
        if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL spurious_ack: rv=%b cyc=%b rdy=%b want 0 0 1", rsp_valid, wbm_cyc_o, cmd_ready);
        end
    endtask

`ifdef WB_CMD_INITIATOR_ERR_EN
    task automatic test_err;
        q.push_back('{code: 2'b10, dat: 32'h0});
        drive_cmd(1'b0, 32'h3000_0100, 32'h0, 4'hF);
        @(negedge clk);
        wbm_err_i = 1'b1;
        wbm_dat_i = 32'h7777_7777;
        @(negedge clk);
        wbm_err_i = 1'b0;
        wbm_dat_i = IDLE_DAT;
        collect_rsp("err");
        q.push_back('{code: 2'b00, dat: 32'h5555_AAAA});
        drive_cmd(1'b0, 32'h3000_0104, 32'h0, 4'hF);
        wbm_err_i = 1'b1;
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h5555_AAAA;
        @(negedge clk);
        wbm_err_i = 1'b0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = IDLE_DAT;
        collect_rsp("err_ack_wins");
    endtask
`endif

    initial begin
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = IDLE_DAT;
`ifdef WB_CMD_INITIATOR_ERR_EN
        wbm_err_i = 1'b0;
`endif
        test_reset();
        test_single_write();
        test_read_wait();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_back_pressure();
        test_back_to_back();
`ifdef WB_CMD_INITIATOR_ERR_EN
        test_err();
`endif
        test_reset_mid();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d left want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_cmd_initiator.md
Name: wb_cmd_initiator

Overview:
- Wishbone classic initiator (master) for the user area: the opposite end of the wbs_* responder port in the user project wrapper.
- Accepts single read/write commands on a valid/ready command channel, fed from LA pins or a local sequencer.
- Runs one Wishbone classic cycle per command and returns the read data and a status code on a valid/ready response channel.
- Includes a bus-timeout watchdog so a responder that never acks cannot hang the initiator.

Parameters:
- ADR_W, 32, address width.
- DAT_W, 32, data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 255, maximum number of stb-high cycles without ack before the cycle is aborted; legal range 2..65535.

Ports:
- wb_clk_i  input  1  clock.
- wb_rst_i  input  1  reset; asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  initiator can accept a command.
- cmd_we  input  1  1 = write, 0 = read.
- cmd_adr  input  ADR_W  byte address.
- cmd_dat  input  DAT_W  write data.
- cmd_sel  input  DAT_W/8  byte selects.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_dat  output  DAT_W  read data; 0 for writes and errors.
- rsp_code  output  2  00 OK, 01 TIMEOUT, 10 BUS_ERR.
- wbm_cyc_o  output  1  Wishbone cycle.
- wbm_stb_o  output  1  Wishbone strobe.
- wbm_we_o  output  1  write enable.
- wbm_sel_o  output  DAT_W/8  byte selects.
- wbm_adr_o  output  ADR_W  address.
- wbm_dat_o  output  DAT_W  write data.
- wbm_ack_i  input  1  responder acknowledge.
- wbm_dat_i  input  DAT_W  responder read data.

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - cmd_ready=1.
  - rsp_valid=0, rsp_dat=0, rsp_code=00.
  - wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0.
  - wbm_sel_o, wbm_adr_o, wbm_dat_o all 0.
  - Timeout counter 0.
- All outputs are registered. There is no combinational path from any input to any output.
- FSM has three states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready at edge T: capture we/adr/dat/sel into the wbm_* registers, set cyc=stb=1, counter=0, go to BUS.
  - cyc/stb are visible from T+1.
- BUS:
  - cmd_ready=0.
  - cyc, stb, we, adr, sel and dat_o are held stable for the whole cycle.
  - Each edge with wbm_ack_i=0 increments the counter.
  - Ack: on the edge where wbm_ack_i=1, drop cyc/stb and go to RESP with rsp_valid=1 and rsp_code=00. rsp_dat captures wbm_dat_i on reads and is 0 on writes.
  - Minimum latency: command at T, ack sampled at T+1, rsp_valid at T+2.
  - Timeout: on the edge where the counter equals TIMEOUT_CYCLES-1 and ack=0, drop cyc/stb and go to RESP with rsp_code=01 and rsp_dat=0.
  - Ack and timeout on the same edge: ack wins, rsp_code=00.
- RESP:
  - rsp_valid is held, with rsp_dat and rsp_code stable, until rsp_ready=1.
  - On that edge: rsp_valid=0, go to IDLE. The next command can be accepted one edge later.
  - cmd_ready=0 throughout RESP. There is no command/response overlap: at most one transaction is outstanding.
- wbm_ack_i while cyc=0 is ignored (no state change, no response).
- Counter width is clog2(TIMEOUT_CYCLES)+1 bits and saturates; it never wraps.
- Reset during BUS or RESP:
  - cyc/stb drop immediately (async).
  - Any pending response is discarded.
  - Returns to IDLE.
- wbm_dat_o/we/sel/adr keep their last values after the cycle ends; only cyc/stb qualify them.

Optional Feature:
- Macro: WB_CMD_INITIATOR_ERR_EN.
- With it defined:
  - Adds input wbm_err_i (1 bit).
  - In BUS, err=1 ends the cycle like ack but with rsp_code=10 and rsp_dat=0.
  - Priority when several fire on one edge: ack > err > timeout.
- Without it: the wbm_err_i port is absent and rsp_code=10 is never produced.

Decomposition:
- Package wb_cmd_initiator_pkg holds:
  - The FSM state enum (IDLE/BUS/RESP).
  - RSP_OK=2'b00, RSP_TIMEOUT=2'b01, RSP_BUS_ERR=2'b10.
- One sub-module, wb_timeout_ctr:
  - Parameter TIMEOUT_CYCLES.
  - Inputs clear and run.
  - Output expired, asserted on the edge where count==TIMEOUT_CYCLES-1.
  - Saturating.

Test Plan:
- Single write: cmd we=1, adr=0x3000_0004, dat=0xDEADBEEF, sel=0xF; responder acks on first stb cycle -> at T+1 bus shows cyc=stb=we=1, adr=0x3000_0004, dat=0xDEADBEEF; rsp_valid at T+2, rsp_code=00, rsp_dat=0.
- Single read with wait states: adr=0x3000_0010, responder acks 3 cycles after stb with dat=0x1234_5678 -> cyc/stb high for exactly 4 cycles with all bus signals stable; rsp_dat=0x1234_5678, rsp_code=00.
- Timeout: TIMEOUT_CYCLES=8, responder never acks -> stb high for exactly 8 cycles, then cyc=0; rsp_code=01, rsp_dat=0. Ack arriving on the 8th stb cycle instead gives rsp_code=00.
- Response back-pressure: rsp_ready held low 5 cycles after rsp_valid, with cmd_valid held high -> rsp_valid, rsp_dat and rsp_code stable; cmd_ready=0; no second bus cycle starts until one edge after the rsp handshake.
- Reset mid-cycle: assert wb_rst_i during BUS between edges -> cyc/stb fall before the next edge; after release cmd_ready=1, rsp_valid=0, and a spurious ack is ignored.
- With WB_CMD_INITIATOR_ERR_EN defined: err=1 on the 2nd stb cycle -> rsp_code=10. Err and ack together -> rsp_code=00.
